// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit
// Fetches 32-bit RV32I instruction words from instruction memory at the
// current PC. Each word is presented on INSN/insn_pc under a valid/ready
// handshake and held until the control unit accepts it. Branch/jump logic
// can redirect the PC at any time. An in-flight memory read that is
// interrupted this way is allowed to finish, and its data is thrown away.
// A misaligned PC or a memory read that never completes raises a sticky
// fetch_err. After that the unit stays in ERR until reset.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   mem_req/mem_addr    read request and address (address stable while req)
//   mem_ack/mem_rdata   read completion and data (ack ignored unless req)
//   INSN/insn_pc        fetched word and the address it came from
//   insn_valid          INSN/insn_pc valid
//   insn_ready          control unit accepts INSN
//   redirect/redirect_pc  load a new fetch PC
//   fetch_err           sticky error flag
module insn_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] INSN,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    // The counter reaches MAX_WAIT on the edge where it currently holds
    // MAX_WAIT-1 and the memory still has not acknowledged.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [31:0]       NOP       = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t            state_reg;
    logic [31:0]       pc_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_req_reg;
    logic [31:0]       mem_addr_reg;
    logic [31:0]       insn_reg;
    logic [31:0]       insn_pc_reg;
    logic              insn_valid_reg;
    logic              fetch_err_reg;

    logic waiting;
    logic timeout;
    logic redirect_bad;
    logic go_err;

    assign waiting      = mem_req_reg && !mem_ack;
    assign timeout      = waiting && (wait_cnt_reg == WAIT_LAST);
    assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);

    // All error sources share one entry path into ERR. A misaligned PC can
    // only be fetched from IDLE, and only when no redirect replaces it.
    assign go_err = (state_reg != S_ERR) &&
                    (redirect_bad || timeout ||
                     ((state_reg == S_IDLE) && !redirect && (pc_reg[1:0] != 2'b00)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            wait_cnt_reg   <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= RESET_PC;
            insn_reg       <= NOP;
            insn_pc_reg    <= 32'h0000_0000;
            insn_valid_reg <= 1'b0;
            fetch_err_reg  <= 1'b0;
        end else begin
            // Counts only outstanding, unacknowledged request cycles. It
            // clears itself whenever a request completes or none is
            // outstanding, which also covers every entry into REQ.
            if (waiting) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end

            if (go_err) begin
                state_reg      <= S_ERR;
                fetch_err_reg  <= 1'b1;
                mem_req_reg    <= 1'b0;
                insn_valid_reg <= 1'b0;
            end else begin
                unique case (state_reg)
                    S_IDLE: begin
                        mem_req_reg <= 1'b1;
                        state_reg   <= S_REQ;
                        if (redirect) begin
                            pc_reg       <= redirect_pc;
                            mem_addr_reg <= redirect_pc;
                        end else begin
                            mem_addr_reg <= pc_reg;
                        end
                    end

                    S_REQ: begin
                        if (redirect) begin
                            pc_reg         <= redirect_pc;
                            insn_valid_reg <= 1'b0;
                            if (mem_ack) begin
                                // The returned word belongs to the old path, so
                                // drop it and start the new fetch at once.
                                mem_addr_reg <= redirect_pc;
                            end else begin
                                // The bus read must still complete at the old
                                // address, so keep the request up until it does.
                                state_reg <= S_DRAIN;
                            end
                        end else if (mem_ack) begin
                            insn_reg       <= mem_rdata;
                            insn_pc_reg    <= pc_reg;
                            insn_valid_reg <= 1'b1;
                            pc_reg         <= pc_reg + 32'd4;
                            mem_req_reg    <= 1'b0;
                            state_reg      <= S_HOLD;
                        end
                    end

                    S_HOLD: begin
                        // A redirect wins over insn_ready. The held word is
                        // discarded, not accepted.
                        if (redirect) begin
                            pc_reg         <= redirect_pc;
                            insn_valid_reg <= 1'b0;
                            mem_req_reg    <= 1'b1;
                            mem_addr_reg   <= redirect_pc;
                            state_reg      <= S_REQ;
                        end else if (insn_valid_reg && insn_ready) begin
                            insn_valid_reg <= 1'b0;
                            mem_req_reg    <= 1'b1;
                            mem_addr_reg   <= pc_reg;
                            state_reg      <= S_REQ;
                        end
                    end

                    S_DRAIN: begin
                        if (redirect) begin
                            pc_reg <= redirect_pc;
                        end
                        if (mem_ack) begin
                            // Discard the stale data. mem_req stays high into
                            // REQ at the latest target.
                            mem_addr_reg <= redirect ? redirect_pc : pc_reg;
                            state_reg    <= S_REQ;
                        end
                    end

                    default: begin
                        state_reg <= S_ERR;
                    end
                endcase
            end
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign INSN       = insn_reg;
    assign insn_pc    = insn_pc_reg;
    assign insn_valid = insn_valid_reg;
    assign fetch_err  = fetch_err_reg;

endmodule

// File: tb/tb_insn_fetch_unit.sv
module tb_insn_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] INSN;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_err;

    int tests_run    = 0;
    int tests_failed = 0;

    insn_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .INSN       (INSN),
        .insn_pc    (insn_pc),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_err  (fetch_err)
    );

    always #5 CLK = ~CLK;

    // Advance one clock edge, then settle past it before sampling/driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        tests_run++;
        if ({mem_req, mem_addr, insn_valid, fetch_err} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req=%b addr=%h valid=%b err=%b, want 0 00000000 0 0",
                     mem_req, mem_addr, insn_valid, fetch_err);
        end
        tests_run++;
        if ({INSN, insn_pc} !== {32'h0000_0013, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_insn: insn=%h pc=%h, want 00000013 00000000", INSN, insn_pc);
        end
        RST = 1'b0;
        step();
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000000", mem_req, mem_addr);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_linear_fetch();
        logic [31:0] exp_insn;
        insn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_insn  = 32'hA000_0000 + 32'(i);
            mem_ack   = 1'b1;
            mem_rdata = exp_insn;
            step();
            mem_ack = 1'b0;
            tests_run++;
            if ({insn_valid, INSN, insn_pc, mem_req} !== {1'b1, exp_insn, 32'(4 * i), 1'b0}) begin
                tests_failed++;
                $display("FAIL linear_insn%0d: valid=%b insn=%h pc=%h req=%b, want 1 %h %h 0",
                         i, insn_valid, INSN, insn_pc, mem_req, exp_insn, 32'(4 * i));
            end
            step();
            tests_run++;
            if ({insn_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'(4 * i + 4)}) begin
                tests_failed++;
                $display("FAIL linear_req%0d: valid=%b req=%b addr=%h, want 0 1 %h",
                         i, insn_valid, mem_req, mem_addr, 32'(4 * i + 4));
            end
            $display("[TB] linear fetch %0d insn=%h pc=%h", i, exp_insn, 32'(4 * i));
        end
    endtask

    task automatic test_backpressure();
        insn_ready = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        for (int i = 0; i < 5; i++) begin
            // Stray acks while no request is outstanding must be ignored.
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_0000 + 32'(i);
            tests_run++;
            if ({insn_valid, INSN, insn_pc, mem_req} !== {1'b1, 32'h1234_5678, 32'h0000_000C, 1'b0}) begin
                tests_failed++;
                $display("FAIL backpressure%0d: valid=%b insn=%h pc=%h req=%b, want 1 12345678 0000000c 0",
                         i, insn_valid, INSN, insn_pc, mem_req);
            end
            step();
        end
        mem_ack    = 1'b0;
        insn_ready = 1'b1;
        step();
        tests_run++;
        if ({insn_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0000_0010}) begin
            tests_failed++;
            $display("FAIL backpressure_release: valid=%b req=%b addr=%h, want 0 1 00000010",
                     insn_valid, mem_req, mem_addr);
        end
        $display("[TB] backpressure held 5 cycles");
    endtask

    task automatic test_redirect_drain();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({mem_req, mem_addr, insn_valid} !== {1'b1, 32'h0000_0010, 1'b0}) begin
                tests_failed++;
                $display("FAIL drain_hold%0d: req=%b addr=%h valid=%b, want 1 00000010 0",
                         i, mem_req, mem_addr, insn_valid);
            end
            if (i == 0) step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        tests_run++;
        if ({mem_req, mem_addr, insn_valid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            tests_failed++;
            $display("FAIL drain_done: req=%b addr=%h valid=%b, want 1 00000100 0",
                     mem_req, mem_addr, insn_valid);
        end
        mem_rdata = 32'h0000_0093;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({insn_valid, INSN, insn_pc} !== {1'b1, 32'h0000_0093, 32'h0000_0100}) begin
            tests_failed++;
            $display("FAIL drain_target: valid=%b insn=%h pc=%h, want 1 00000093 00000100",
                     insn_valid, INSN, insn_pc);
        end
        step();
        $display("[TB] redirect during outstanding request to 00000100");
    endtask

    task automatic test_redirect_with_ack();
        mem_ack     = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        tests_run++;
        if ({insn_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0000_0200}) begin
            tests_failed++;
            $display("FAIL redirect_ack: valid=%b req=%b addr=%h, want 0 1 00000200",
                     insn_valid, mem_req, mem_addr);
        end
        mem_rdata = 32'h0000_0113;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({insn_valid, INSN, insn_pc} !== {1'b1, 32'h0000_0113, 32'h0000_0200}) begin
            tests_failed++;
            $display("FAIL redirect_ack_target: valid=%b insn=%h pc=%h, want 1 00000113 00000200",
                     insn_valid, INSN, insn_pc);
        end
        // Redirect beats insn_ready while holding.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        tests_run++;
        if ({insn_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0000_0300}) begin
            tests_failed++;
            $display("FAIL redirect_hold: valid=%b req=%b addr=%h, want 0 1 00000300",
                     insn_valid, mem_req, mem_addr);
        end
        $display("[TB] redirect with same-cycle ack and over ready");
    endtask

    task automatic test_pc_wrap();
        mem_ack     = 1'b1;
        mem_rdata   = 32'h0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect  = 1'b0;
        mem_rdata = 32'h0000_0213;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({insn_valid, insn_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            tests_failed++;
            $display("FAIL wrap_insn: valid=%b pc=%h, want 1 fffffffc", insn_valid, insn_pc);
        end
        step();
        tests_run++;
        if ({mem_req, mem_addr, fetch_err} !== {1'b1, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_next: req=%b addr=%h err=%b, want 1 00000000 0",
                     mem_req, mem_addr, fetch_err);
        end
        $display("[TB] pc wrap fffffffc -> 00000000");
    endtask

    task automatic test_misaligned();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({fetch_err, mem_req, insn_valid} !== {1'b1, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL misaligned%0d: err=%b req=%b valid=%b, want 1 0 0",
                         i, fetch_err, mem_req, insn_valid);
            end
            mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        tests_run++;
        if ({fetch_err, mem_req} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL misaligned_rst: err=%b req=%b, want 0 0", fetch_err, mem_req);
        end
        step();
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL misaligned_refetch: req=%b addr=%h, want 1 00000000", mem_req, mem_addr);
        end
        $display("[TB] misaligned redirect 00000102 flagged and cleared by reset");
    endtask

    task automatic test_timeout();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({fetch_err, mem_req} !== {1'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL timeout_wait%0d: err=%b req=%b, want 0 1", i, fetch_err, mem_req);
            end
        end
        step();
        tests_run++;
        if ({fetch_err, mem_req} !== {1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_err: err=%b req=%b, want 1 0", fetch_err, mem_req);
        end
        $display("[TB] timeout after 4 waiting cycles");
    endtask

    initial begin
        test_reset();
        test_linear_fetch();
        test_backpressure();
        test_redirect_drain();
        test_redirect_with_ack();
        test_pc_wrap();
        test_misaligned();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
